// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select of a shared 4:1
// data mux. One requester is granted at a time and keeps the grant while it
// holds its request high. The selected data is registered onto y.
// Optional feature macro: HOLD_TIMEOUT_EN. When it is defined, an owner that
// has held the grant for MAX_HOLD cycles is forced to rotate if anyone else
// is waiting.
module mux4_rr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] d,
   output logic [3:0]         gnt,
   output logic [1:0]         s,
   output logic               gnt_valid,
   output logic [WIDTH-1:0]   y,
   output logic               y_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [1:0]         s_q, s_d;
   logic [1:0]         last_q, last_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               y_valid_q, y_valid_d;

`ifdef HOLD_TIMEOUT_EN
   localparam logic [7:0] HoldLimit = 8'(MAX_HOLD - 1);
   logic [7:0]         hold_q, hold_d;
   logic [3:0]         others;
`endif

   // Returns {found, index}: the first set request bit scanning from the
   // position just after lst and wrapping round, so lst itself comes last.
   function automatic logic [2:0] pickNext(input logic [3:0] r, input logic [1:0] lst);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = lst + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   logic [2:0] winIdle;
   logic [2:0] winRel;

   assign winIdle = pickNext(req, last_q);
   assign winRel  = pickNext(req, s_q);

   // Next-state logic for the grant FSM, the select and the rotation pointer.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      s_d     = s_q;
      last_d  = last_q;
`ifdef HOLD_TIMEOUT_EN
      hold_d  = hold_q;
      others  = req & ~(4'b0001 << s_q);
`endif
      case (state_q)
         IDLE: begin
            if (winIdle[2]) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << winIdle[1:0];
               s_d     = winIdle[1:0];
`ifdef HOLD_TIMEOUT_EN
               hold_d  = 8'd0;
`endif
            end
         end
         GRANT: begin
            if (req[s_q]) begin
`ifdef HOLD_TIMEOUT_EN
               if (hold_q == HoldLimit) begin
                  hold_d = 8'd0;
                  if (others != 4'b0000) begin
                     last_d = s_q;
                     gnt_d  = 4'b0001 << winRel[1:0];
                     s_d    = winRel[1:0];
                  end
               end else if (hold_q != 8'hFF) begin
                  hold_d = hold_q + 8'd1;
               end
`endif
            end else begin
               last_d = s_q;
               if (winRel[2]) begin
                  gnt_d  = 4'b0001 << winRel[1:0];
                  s_d    = winRel[1:0];
`ifdef HOLD_TIMEOUT_EN
                  hold_d = 8'd0;
`endif
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // Registered mux output: capture the owner's data while it still requests.
   always_comb begin
      y_valid_d = gnt_valid && req[s_q];
      y_d       = y_q;
      if (y_valid_d) y_d = d[s_q*WIDTH +: WIDTH];
   end

   // State registers with synchronous reset; pointer resets to 3 so that
   // requester 0 has top priority afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         s_q       <= 2'd0;
         last_q    <= 2'd3;
         y_q       <= '0;
         y_valid_q <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
         hold_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         s_q       <= s_d;
         last_q    <= last_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
`ifdef HOLD_TIMEOUT_EN
         hold_q    <= hold_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign s         = s_q;
   assign gnt_valid = |gnt_q;
   assign y         = y_q;
   assign y_valid   = y_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter. Directed vectors push their hand-computed
// expected outputs into a queue tagged with the clock edge they apply after;
// a separate monitor pops and compares on the falling edge.
module tb_mux4_rr_arbiter;

   logic        clock;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] d;
   logic [3:0]  gnt;
   logic [1:0]  s;
   logic        gntValid;
   logic [7:0]  y;
   logic        yValid;

   typedef struct {
      int         due;
      logic [3:0] g;
      logic [1:0] s;
      logic [7:0] y;
      logic       yv;
   } exp_t;

   exp_t expQ[$];
   int   edgeCount = 0;
   int   checks    = 0;
   int   errors    = 0;

   logic [7:0] dv [4];

   mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
      .clk       (clock),
      .rst       (rst),
      .req       (req),
      .d         (d),
      .gnt       (gnt),
      .s         (s),
      .gnt_valid (gntValid),
      .y         (y),
      .y_valid   (yValid)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Edge counter used to time-tag expected responses.
   always @(posedge clock) edgeCount <= edgeCount + 1;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req8);
      checks++;
      if (act !== req8) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, edgeCount, act, req8);
      end
   endtask

   // Monitor: compare the record due after the most recent rising edge.
   always @(negedge clock) begin
      exp_t e;
      if (expQ.size() > 0 && expQ[0].due == edgeCount) begin
         e = expQ.pop_front();
         checkOutput("gnt",       {4'b0, gnt},      {4'b0, e.g});
         checkOutput("s",         {6'b0, s},        {6'b0, e.s});
         checkOutput("gnt_valid", {7'b0, gntValid}, {7'b0, |e.g});
         checkOutput("y",         y,                e.y);
         checkOutput("y_valid",   {7'b0, yValid},   {7'b0, e.yv});
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                input logic [1:0] sv, input logic [7:0] yd, input logic yv);
      exp_t e;
      rst = r;
      req = rq;
      e.due = edgeCount + 1;
      e.g   = g;
      e.s   = sv;
      e.y   = yd;
      e.yv  = yv;
      expQ.push_back(e);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [1:0] own;
      logic [1:0] prevOwn;
      dv[0] = 8'hA5; dv[1] = 8'hB6; dv[2] = 8'hC7; dv[3] = 8'hD8;
      d   = {dv[3], dv[2], dv[1], dv[0]};
      rst = 1'b1;
      req = 4'b0000;

      // Reset state
      applyStimulus(1, 4'b0000, 4'b0000, 2'd0, 8'h00, 0);
      applyStimulus(1, 4'b0001, 4'b0000, 2'd0, 8'h00, 0);

      // Single requester: grant latency 1, data latency 1 more
      applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 8'h00, 0);
      applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 8'hA5, 1);

      // All requesting, each owner drops for one cycle in turn
      applyStimulus(0, 4'b1111, 4'b0001, 2'd0, 8'hA5, 1);
      applyStimulus(0, 4'b1110, 4'b0010, 2'd1, 8'hA5, 0);
      applyStimulus(0, 4'b1111, 4'b0010, 2'd1, 8'hB6, 1);
      applyStimulus(0, 4'b1101, 4'b0100, 2'd2, 8'hB6, 0);
      applyStimulus(0, 4'b1111, 4'b0100, 2'd2, 8'hC7, 1);
      applyStimulus(0, 4'b1011, 4'b1000, 2'd3, 8'hC7, 0);
      applyStimulus(0, 4'b1111, 4'b1000, 2'd3, 8'hD8, 1);
      applyStimulus(0, 4'b0111, 4'b0001, 2'd0, 8'hD8, 0);
      applyStimulus(0, 4'b1111, 4'b0001, 2'd0, 8'hA5, 1);

      // Owner 2 releases with nobody waiting, then requester 0 returns
      applyStimulus(0, 4'b0100, 4'b0100, 2'd2, 8'hA5, 0);
      applyStimulus(0, 4'b0100, 4'b0100, 2'd2, 8'hC7, 1);
      applyStimulus(0, 4'b0000, 4'b0000, 2'd2, 8'hC7, 0);
      applyStimulus(0, 4'b0000, 4'b0000, 2'd2, 8'hC7, 0);
      applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 8'hC7, 0);
      applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 8'hA5, 1);

      // Owner 1 interrupted by a reset pulse, regranted from pointer 3
      applyStimulus(0, 4'b0010, 4'b0010, 2'd1, 8'hA5, 0);
      applyStimulus(0, 4'b0010, 4'b0010, 2'd1, 8'hB6, 1);
      applyStimulus(1, 4'b0010, 4'b0000, 2'd0, 8'h00, 0);
      applyStimulus(0, 4'b0010, 4'b0010, 2'd1, 8'h00, 0);
      applyStimulus(0, 4'b0010, 4'b0010, 2'd1, 8'hB6, 1);

      // Release with a new request in the same cycle; then go idle
      applyStimulus(0, 4'b0101, 4'b0100, 2'd2, 8'hB6, 0);
      applyStimulus(0, 4'b0000, 4'b0000, 2'd2, 8'hB6, 0);

      // Two requesters held for 20 cycles (pointer is 2, so 0 wins first)
      prevOwn = 2'd0;
      for (int k = 1; k <= 20; k++) begin
`ifdef HOLD_TIMEOUT_EN
         own = (((k - 1) / 4) % 2 == 1) ? 2'd1 : 2'd0;
`else
         own = 2'd0;
`endif
         if (k == 1) applyStimulus(0, 4'b0011, 4'b0001 << own, own, 8'hB6, 0);
         else        applyStimulus(0, 4'b0011, 4'b0001 << own, own, dv[prevOwn], 1);
         prevOwn = own;
      end

      // Lone requester 0 keeps its grant indefinitely
      for (int k = 0; k < 10; k++)
         applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 8'hA5, 1);

      req = 4'b0000;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expected records never compared, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
